// File: rtl/uart_transmitter_if.sv
// Write-side bus and FIFO status of the UART transmitter: the host drives writes/flush, the transmitter reports status.
interface uart_transmitter_if;
  logic       tx_fifo_we;
  logic [7:0] tx_data;
  logic       tx_fifo_clr;
  logic       tx_busy;
  logic [4:0] tx_fifo_count;
  logic       tx_fifo_empty;
  logic       tx_fifo_full;

  modport master (
    output tx_fifo_we, tx_data, tx_fifo_clr,
    input  tx_busy, tx_fifo_count, tx_fifo_empty, tx_fifo_full
  );

  modport slave (
    input  tx_fifo_we, tx_data, tx_fifo_clr,
    output tx_busy, tx_fifo_count, tx_fifo_empty, tx_fifo_full
  );
endinterface

// File: rtl/uart_transmitter.sv
// 16550-style UART transmitter: write buffer, 16x-oversampled serialiser with parity, stop length and break.
// UART_TX_FIFO_EN selects the 16-entry FIFO; otherwise a single holding register buffers one byte.
module uart_transmitter (
  input  logic                PCLK,
  input  logic                PRESET,
  uart_transmitter_if.slave   bus,
  input  logic                tx_enable,
  input  logic [7:0]          LCR,
  input  logic                loopback,
  output logic                txd,
  output logic                lb_txd
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_tick, w_tick_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic       r_stop2, w_stop2_nxt;
  logic [7:0] r_data;
  logic [1:0] r_wls;
  logic       r_pen, r_stb, r_par;
  logic       w_pop, w_load, w_push, w_nempty, w_last, w_tick_end, w_serial;
  logic [7:0] w_head, w_dmask;
  logic       w_unused;

  assign w_unused = LCR[7];
  assign w_push   = bus.tx_fifo_we && (!bus.tx_fifo_full || w_pop);

`ifdef UART_TX_FIFO_EN
  logic [7:0] r_mem [16];
  logic [3:0] r_wptr, r_rptr;
  logic [4:0] r_cnt;

  assign w_head            = r_mem[r_rptr];
  assign bus.tx_fifo_count = r_cnt;
  assign bus.tx_fifo_full  = (r_cnt == 5'd16);

  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wptr] <= bus.tx_data;
  end

  // Flush wins over a simultaneous write; a byte popped in the same cycle is already latched by the FSM.
  always_ff @(posedge PCLK) begin
    if (PRESET || bus.tx_fifo_clr) begin
      r_wptr <= 4'd0;
      r_rptr <= 4'd0;
      r_cnt  <= 5'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 4'd1;
      if (w_pop)  r_rptr <= r_rptr + 4'd1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 5'd1;
        2'b01:   r_cnt <= r_cnt - 5'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_full;

  assign w_head            = r_hold;
  assign bus.tx_fifo_count = {4'd0, r_full};
  assign bus.tx_fifo_full  = r_full;

  always_ff @(posedge PCLK) begin
    if (w_push) r_hold <= bus.tx_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || bus.tx_fifo_clr) r_full <= 1'b0;
    else if (w_push)               r_full <= 1'b1;
    else if (w_pop)                r_full <= 1'b0;
  end
`endif

  assign bus.tx_fifo_empty = (bus.tx_fifo_count == 5'd0);
  assign w_nempty          = !bus.tx_fifo_empty;
  assign bus.tx_busy       = (r_state != IDLE);

  assign w_last     = (r_bit == ({1'b0, r_wls} + 3'd4));
  assign w_tick_end = tx_enable && (r_tick == 4'd15);
  assign w_dmask    = w_head & (8'hFF >> (2'd3 - LCR[1:0]));

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = tx_enable ? r_tick + 4'd1 : r_tick;
    w_bit_nxt   = r_bit;
    w_stop2_nxt = r_stop2;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_nxt = 4'd0;
        if (tx_enable && w_nempty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick_end) begin
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick_end) begin
          if (w_last) w_state_nxt = r_pen ? PARITY : STOP;
          else        w_bit_nxt   = r_bit + 3'd1;
        end
      end
      PARITY: begin
        if (w_tick_end) w_state_nxt = STOP;
      end
      STOP: begin
        // Long stop = 16 ticks plus a second phase of 16, or 8 for 5-bit words (1.5 bits).
        if (tx_enable && ((r_stop2 && r_wls == 2'd0 && r_tick == 4'd7) ||
                          (r_tick == 4'd15 && !(r_stb && !r_stop2)))) begin
          w_tick_nxt  = 4'd0;
          w_stop2_nxt = 1'b0;
          if (w_nempty) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_tick_end) begin
          w_stop2_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_stop2 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_stop2 <= w_stop2_nxt;
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_load) begin
      r_data <= w_head;
      r_wls  <= LCR[1:0];
      r_stb  <= LCR[2];
      r_pen  <= LCR[3];
      r_par  <= LCR[5] ? ~LCR[4] : (LCR[4] ? ^w_dmask : ~^w_dmask);
    end
  end

  always_comb begin
    w_serial = 1'b1;
    case (r_state)
      START:   w_serial = 1'b0;
      DATA:    w_serial = r_data[r_bit];
      PARITY:  w_serial = r_par;
      default: w_serial = 1'b1;
    endcase
  end

  // Break is applied live to the pin only; the loopback path always sees the real frame.
  assign lb_txd = w_serial;
  assign txd    = loopback ? 1'b1 : (LCR[6] ? 1'b0 : w_serial);

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: queued (data, LCR) frames are decoded from lb_txd/txd and checked bit by bit.
module tb_uart_transmitter;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [7:0] lcr;
    logic [7:0] data;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       tx_enable;
  logic [7:0] LCR;
  logic       loopback;
  logic       txd, lb_txd;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sb_q[$];

  uart_transmitter_if tif ();

  uart_transmitter dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .bus       (tif),
    .tx_enable (tx_enable),
    .LCR       (LCR),
    .loopback  (loopback),
    .txd       (txd),
    .lb_txd    (lb_txd)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bit_chk(input string tag, input logic b);
    check({tag, "_lb"}, lb_txd, b);
    check({tag, "_txd"}, txd, loopback ? 1'b1 : (LCR[6] ? 1'b0 : b));
  endtask

  task automatic wr(input logic [7:0] d, input bit push);
    tif.tx_fifo_we = 1'b1;
    tif.tx_data    = d;
    if (push) sb_q.push_back('{lcr: LCR, data: d});
    @(negedge PCLK);
    tif.tx_fifo_we = 1'b0;
  endtask

  task automatic mon_frame();
    exp_t       e;
    int         t, nb, stop_exp, n, t0;
    logic [7:0] dm;
    logic       pe;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e  = sb_q.pop_front();
    nb = 5 + int'(e.lcr[1:0]);
    dm = 8'h00;
    for (int i = 0; i < nb; i++) dm[i] = e.data[i];
    pe = e.lcr[5] ? ~e.lcr[4] : (e.lcr[4] ? ^dm : ~^dm);
    stop_exp = !e.lcr[2] ? 16 : (nb == 5 ? 24 : 32);
    t = 0;
    while (lb_txd !== 1'b0 && t < 400) begin
      @(negedge PCLK);
      t++;
    end
    check("start_edge", lb_txd, 0);
    t0 = cyc;
    repeat (7) @(negedge PCLK);
    bit_chk("start", 1'b0);
    check("busy_in_frame", tif.tx_busy, 1);
    for (int i = 0; i < nb; i++) begin
      repeat (16) @(negedge PCLK);
      bit_chk("data", e.data[i]);
    end
    if (e.lcr[3]) begin
      repeat (16) @(negedge PCLK);
      bit_chk("parity", pe);
    end
    repeat (9) @(negedge PCLK);
    bit_chk("stop", 1'b1);
    n = 0;
    while (lb_txd === 1'b1 && tif.tx_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge PCLK);
    end
    check("stop_len", n, stop_exp);
    check("frame_len", cyc - t0, 16 * (1 + nb + int'(e.lcr[3])) + stop_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tbl [8];
    int          m;
    tbl = '{16'h0355, 16'h1B07, 16'h0B07, 16'h2BA3, 16'h3BA3, 16'h041F, 16'h07C4, 16'h0D5A};
    PRESET = 1'b1;
    tx_enable = 1'b0;
    LCR = 8'h03;
    loopback = 1'b0;
    tif.tx_fifo_we = 1'b0;
    tif.tx_data = 8'h00;
    tif.tx_fifo_clr = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_txd", txd, 1);
    check("rst_lb_txd", lb_txd, 1);
    check("rst_busy", tif.tx_busy, 0);
    check("rst_count", tif.tx_fifo_count, 0);
    check("rst_empty", tif.tx_fifo_empty, 1);
    check("rst_full", tif.tx_fifo_full, 0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Format table: 8N1, even/odd/stick parity, 5-bit with 1.5 stop, 8-bit with 2 stop, 6-bit odd.
    tx_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      LCR = tbl[k][15:8];
      wr(tbl[k][7:0], 1'b1);
      mon_frame();
    end

    // Frame format is latched at frame start; later LCR edits must not affect it.
    LCR = 8'h09;
    wr(8'h2D, 1'b1);
    fork
      mon_frame();
      begin repeat (20) @(negedge PCLK); LCR = 8'h1F; end
    join
    LCR = 8'h03;

    loopback = 1'b1;
    wr(8'h96, 1'b1);
    mon_frame();
    loopback = 1'b0;

    wr(8'h3C, 1'b1);
    fork
      mon_frame();
      begin repeat (20) @(negedge PCLK); LCR = 8'h43; end
    join
    LCR = 8'h03;
    @(negedge PCLK);
    check("brk_idle_busy", tif.tx_busy, 0);

    // Fill with ticks stopped, one byte past capacity, then drain back-to-back.
    tx_enable = 1'b0;
    m = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      wr(8'(k * 37 + 5), m < DEPTH);
      if (m < DEPTH) m++;
    end
    repeat (5) @(negedge PCLK);
    check("fill_count", tif.tx_fifo_count, DEPTH);
    check("fill_full", tif.tx_fifo_full, 1);
    check("fill_empty", tif.tx_fifo_empty, 0);
    check("fill_stalled_busy", tif.tx_busy, 0);
    tx_enable = 1'b1;
    for (int k = 0; k < DEPTH; k++) mon_frame();
    check("drain_empty", tif.tx_fifo_empty, 1);
    repeat (30) @(negedge PCLK);
    check("drain_no_extra", tif.tx_busy, 0);

    // Flush beats a simultaneous write.
    tx_enable = 1'b0;
    wr(8'hA1, 1'b0);
    tif.tx_fifo_clr = 1'b1;
    wr(8'hB2, 1'b0);
    tif.tx_fifo_clr = 1'b0;
    check("clr_count", tif.tx_fifo_count, 0);
    check("clr_empty", tif.tx_fifo_empty, 1);
    tx_enable = 1'b1;
    repeat (20) @(negedge PCLK);
    check("clr_no_frame", tif.tx_busy, 0);

    // Reset in the middle of the data bits aborts the frame.
    wr(8'hA5, 1'b0);
    wr(8'h5A, 1'b0);
    repeat (60) @(negedge PCLK);
    check("pre_rst_busy", tif.tx_busy, 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("midrst_txd", txd, 1);
    check("midrst_lb", lb_txd, 1);
    check("midrst_busy", tif.tx_busy, 0);
    check("midrst_count", tif.tx_fifo_count, 0);
    repeat (40) @(negedge PCLK);
    check("midrst_no_resume", tif.tx_busy, 0);
    check("midrst_txd_hold", lb_txd, 1);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
